// File: rtl/pea_writeback_ctrl.sv
// rtl/pea_writeback_ctrl.sv - PE array result writeback into ping-pong buffer m1 port with 2-D addressing
// Optional dropped-word counter enabled by defining PEA_WB_DROP_CNT_EN.
module pea_writeback_ctrl #(
   parameter int BUS_W  = 256,
   parameter int ADDR_W = 16
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              start,
   input  logic              abort,
   input  logic              dest_sel,
   input  logic [ADDR_W-1:0] base_addr,
   input  logic [ADDR_W-1:0] row_len,
   input  logic [ADDR_W-1:0] num_rows,
   input  logic [ADDR_W-1:0] row_stride,
   input  logic              pea_out_valid,
   input  logic [BUS_W-1:0]  pea_out_data,
   output logic              pea_out_ready,
   output logic [BUS_W-1:0]  m1_input_bus,
   output logic              buf1_m1_w_en,
   output logic              buf2_m1_w_en,
   output logic [ADDR_W-1:0] buf1_m1_w_addr,
   output logic [ADDR_W-1:0] buf2_m1_w_addr,
   output logic              busy,
   output logic              done,
   output logic [15:0]       drop_cnt
);

   typedef enum logic [1:0] {S_IDLE, S_ACTIVE, S_DRAIN, S_DONE} state_t;

   state_t            r_state;
   state_t            w_next;

   logic              r_dest_sel;
   logic [ADDR_W-1:0] r_row_len;
   logic [ADDR_W-1:0] r_num_rows;
   logic [ADDR_W-1:0] r_row_stride;
   logic [ADDR_W-1:0] r_row;
   logic [ADDR_W-1:0] r_col;
   logic [ADDR_W-1:0] r_row_base;

   logic              r_w_en1;
   logic              r_w_en2;
   logic [ADDR_W-1:0] r_addr;
   logic [BUS_W-1:0]  r_data;
   logic              r_busy;
   logic              r_done;

   logic              w_launch;
   logic              w_zero;
   logic              w_col_end;
   logic              w_last;
   logic              w_ready;
   logic              w_accept;
   logic              w_busy_nxt;
   logic              w_done_nxt;

   assign w_launch  = (r_state == S_IDLE) && start && !abort;
   assign w_zero    = (row_len == '0) || (num_rows == '0);
   assign w_col_end = (r_col == r_row_len - ADDR_W'(1));
   assign w_last    = w_col_end && (r_row == r_num_rows - ADDR_W'(1));

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state <= S_IDLE;
      end else begin
         r_state <= w_next;
      end
   end

   // Zero-size jobs pass through DRAIN so done lands two cycles after start.
   always_comb begin
      w_next = r_state;
      if (abort && (r_state != S_IDLE)) begin
         w_next = S_IDLE;
      end else begin
         case (r_state)
            S_IDLE:   if (w_launch) w_next = w_zero ? S_DRAIN : S_ACTIVE;
            S_ACTIVE: if (w_accept && w_last) w_next = S_DRAIN;
            S_DRAIN:  w_next = S_DONE;
            S_DONE:   w_next = S_IDLE;
            default:  w_next = S_IDLE;
         endcase
      end
   end

   always_comb begin
      w_ready    = (r_state == S_ACTIVE) && !abort;
      w_accept   = w_ready && pea_out_valid;
      w_busy_nxt = (w_next != S_IDLE);
      w_done_nxt = (w_next == S_DONE);
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_dest_sel   <= 1'b0;
         r_row_len    <= '0;
         r_num_rows   <= '0;
         r_row_stride <= '0;
         r_row        <= '0;
         r_col        <= '0;
         r_row_base   <= '0;
      end else if (w_launch) begin
         r_dest_sel   <= dest_sel;
         r_row_len    <= row_len;
         r_num_rows   <= num_rows;
         r_row_stride <= row_stride;
         r_row        <= '0;
         r_col        <= '0;
         r_row_base   <= base_addr;
      end else if (w_accept) begin
         if (w_col_end) begin
            r_col      <= '0;
            r_row      <= r_row + ADDR_W'(1);
            r_row_base <= r_row_base + r_row_stride;
         end else begin
            r_col      <= r_col + ADDR_W'(1);
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_w_en1 <= 1'b0;
         r_w_en2 <= 1'b0;
         r_addr  <= '0;
         r_data  <= '0;
         r_busy  <= 1'b0;
         r_done  <= 1'b0;
      end else begin
         r_w_en1 <= w_accept && !r_dest_sel;
         r_w_en2 <= w_accept && r_dest_sel;
         r_busy  <= w_busy_nxt;
         r_done  <= w_done_nxt;
         if (w_accept) begin
            r_addr <= r_row_base + r_col;
            r_data <= pea_out_data;
         end
      end
   end

`ifdef PEA_WB_DROP_CNT_EN
   logic [15:0] r_drop_cnt;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_drop_cnt <= '0;
      end else if (w_launch) begin
         r_drop_cnt <= '0;
      end else if (pea_out_valid && !w_ready && r_busy && (r_drop_cnt != 16'hFFFF)) begin
         r_drop_cnt <= r_drop_cnt + 16'd1;
      end
   end

   assign drop_cnt = r_drop_cnt;
`else
   assign drop_cnt = 16'd0;
`endif

   assign pea_out_ready  = w_ready;
   assign m1_input_bus   = r_data;
   assign buf1_m1_w_en   = r_w_en1;
   assign buf2_m1_w_en   = r_w_en2;
   assign buf1_m1_w_addr = r_addr;
   assign buf2_m1_w_addr = r_addr;
   assign busy           = r_busy;
   assign done           = r_done;

endmodule
